ahb_timer_slave: RTL and testbench
==================================

# ahb_timer_slave

AHB-Lite responder that exposes a 32-bit down-counting timer with interrupt to the core's AHB master port. It sits behind the AHB interconnect as a third slave, beside the instruction and data memories. It decodes pipelined address/data phases and returns zero-wait-state OKAY or the two-cycle ERROR response. It drives one level interrupt line.

## Interface
Parameters:
- ADDR_W, 12: number of low address bits decoded; higher bits are ignored because the interconnect already decoded them.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select from the interconnect.
- haddr  in  32  address-phase address.
- htrans  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size; only 3'b010 (word) is legal.
- hprot  in  4  protection; accepted and ignored.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-level ready; an address phase is accepted only when it is 1.
- hrdata  out  32  read data, valid in the data phase.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- timer_irq  out  1  level interrupt.

## Operation
- Address phase accepted when hsel & htrans[1] & hready. Latch offset, hwrite, and the error flag into data-phase registers.
- Register map (offset = haddr[ADDR_W-1:0]):
  - 0x0 CTRL, RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read 0.
  - 0x4 LOAD, RW. A write also copies hwdata into COUNT.
  - 0x8 COUNT, RO.
  - 0xC STATUS: bit0 EXPIRED. Write 1 to clear.
- ERROR is returned for any of:
  - hsize != 010;
  - haddr[1:0] != 0;
  - a write to COUNT;
  - an unmapped offset.
  An ERROR transfer changes no register.
- Response FSM:
  - OKAY → ERR1 when an error transfer is accepted.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → OKAY, or back to ERR1 if another error transfer is accepted in that cycle.
- Counter, per tick while EN=1:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: set EXPIRED. If AUTO_RELOAD, COUNT <= LOAD; otherwise EN clears.
- timer_irq = EXPIRED & IRQ_EN (combinational from flops).
- Simultaneous events:
  - EXPIRED set and a write-1-clear in the same cycle: set wins.
  - Bus write to LOAD/COUNT and a tick in the same cycle: the bus write wins.
- Reset mid-transfer aborts the transfer. The FSM returns to OKAY.

## Timing
- Reset values:
  - hrdata=0, hreadyout=1, hresp=0, timer_irq=0;
  - CTRL=0, LOAD=0, COUNT=0, STATUS=0;
  - FSM=OKAY.
- Reads: zero wait states. hrdata is registered and valid in the cycle after the address phase.
- Writes: hwdata is sampled on the clock edge that ends the data phase. The new value is readable by a back-to-back read issued in the next address phase.
- ERROR: two cycles.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
  - No new address phase is taken in ERR1, because hready is 0.
- Tick takes effect on the same clock edge as the register update. EXPIRED is set and timer_irq rises 1 cycle after the edge on which COUNT was 0.

## Configuration
- TIMER_PRESCALER_EN defined:
  - Adds register 0x10 PRESC, RW, bits[7:0], reset 0.
  - One tick every PRESC+1 clocks; the internal prescale counter restarts on any PRESC write.
- TIMER_PRESCALER_EN undefined: one tick every clock, and offset 0x10 returns ERROR.

## Structure
- Shared package ahb_pkg holds:
  - htrans_e enum;
  - HSIZE_WORD constant;
  - resp_state_e enum {RESP_OKAY, RESP_ERR1, RESP_ERR2};
  - register offset localparams TMR_CTRL, TMR_LOAD, TMR_COUNT, TMR_STATUS, TMR_PRESC.
- One sub-module, ahb_slave_if. It handles address-phase capture, error decode and the response FSM, and is reusable by later slaves. Register and counter logic stay in ahb_timer_slave.

## Test plan
- Reset asserted mid-ERR1 → next cycle hreadyout=1, hresp=0, hrdata=0, all registers 0.
- Write LOAD=5, then CTRL=0x5 → COUNT reads 5,4,…,0. EXPIRED=1 and timer_irq=1 one cycle after COUNT=0. EN clears to 0.
- AUTO_RELOAD with LOAD=2 → COUNT sequence 2,1,0,2,1,0. EXPIRED is held until STATUS is written with 1. A clear in the same cycle as expiry leaves EXPIRED=1.
- Write to COUNT (0x8), a byte read (hsize=000), and an access to 0x14 → each gets hreadyout 0 then 1 with hresp=1 on both cycles, and register contents are unchanged.
- Back-to-back NONSEQ write LOAD=0xDEADBEEF followed by a read of LOAD → hrdata=0xDEADBEEF in the following data phase with zero wait states.
- With TIMER_PRESCALER_EN, PRESC=3, LOAD=2 → COUNT decrements every 4 clocks. Without the macro, a read of 0x10 → ERROR.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions plus the timer slave register map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        RESP_OKAY,
        RESP_ERR1,
        RESP_ERR2
    } resp_state_e;

    // Timer register offsets within the slave window
    localparam logic [31:0] TMR_CTRL   = 32'h0000_0000;
    localparam logic [31:0] TMR_LOAD   = 32'h0000_0004;
    localparam logic [31:0] TMR_COUNT  = 32'h0000_0008;
    localparam logic [31:0] TMR_STATUS = 32'h0000_000C;
    localparam logic [31:0] TMR_PRESC  = 32'h0000_0010;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IRQ  = 2;

endpackage

// File: rtl/ahb_slave_if.sv
// Generic AHB-Lite slave front end: address-phase capture, error decode, OKAY/ERROR response FSM.
// Latency: reads flagged in the address phase, writes flagged in the data phase; zero wait states for OKAY.
// Backpressure: ERROR responses stall one cycle (hreadyout=0 in ERR1), otherwise never stalls.
module ahb_slave_if
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic              hready,
    input  logic              map_ok_i,   // offset/direction is legal for the owning slave
    output logic              hreadyout,
    output logic              hresp,
    output logic              rd_en_o,    // legal read accepted in this address phase
    output logic              wr_en_o,    // legal write completes at the end of this data phase
    output logic [ADDR_W-1:0] wr_addr_o
);

    htrans_e           trans;
    logic              accept;
    logic              acc_err;
    logic              wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    resp_state_e       state_q;
    logic              hreadyout_q, hresp_q;
    logic              unused_haddr;

    assign trans   = htrans_e'(htrans);
    assign accept  = hsel & hready & ((trans == HTRANS_NONSEQ) | (trans == HTRANS_SEQ));
    assign acc_err = accept & ((hsize != HSIZE_WORD) | (haddr[1:0] != 2'b00) | ~map_ok_i);

    assign rd_en_o      = accept & ~acc_err & ~hwrite;
    assign wr_en_o      = wr_pend_q;
    assign wr_addr_o    = wr_addr_q;
    assign hreadyout    = hreadyout_q;
    assign hresp        = hresp_q;
    assign unused_haddr = ^haddr;

    // Next data-phase write: only legal writes reach the register file
    always_comb begin
        wr_pend_d = accept & ~acc_err & hwrite;
        wr_addr_d = accept ? haddr[ADDR_W-1:0] : wr_addr_q;
    end

    // Data-phase write capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // Response FSM with registered hreadyout/hresp
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RESP_OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            case (state_q)
                RESP_ERR1: begin
                    state_q     <= RESP_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                RESP_OKAY, RESP_ERR2: begin
                    if (acc_err) begin
                        state_q     <= RESP_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b1;
                    end else begin
                        state_q     <= RESP_OKAY;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= RESP_OKAY;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_timer_slave.sv
// AHB-Lite 32-bit down-counting timer with level interrupt; optional PRESC register under TIMER_PRESCALER_EN.
// Latency: read data registered, valid in the data phase; writes take effect at the end of the data phase.
// Backpressure: zero wait states; ERROR transfers insert one stall cycle.
module ahb_timer_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic        timer_irq
);

    logic              map_ok;
    logic              rd_en, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       a_off, w_off, rd_val;
    logic              tick, expire;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [31:0]       load_q, load_d;
    logic [31:0]       count_q, count_d;
    logic              expired_q, expired_d;
    logic [31:0]       hrdata_q, hrdata_d;
    logic              unused_top;

    assign a_off      = 32'(haddr[ADDR_W-1:0]);
    assign w_off      = 32'(wr_addr);
    assign hrdata     = hrdata_q;
    assign timer_irq  = expired_q & ctrl_q[CTRL_IRQ];
    assign unused_top = ^{hprot, haddr};

    ahb_slave_if #(.ADDR_W(ADDR_W)) u_if (
        .clk      (clk),
        .reset    (reset),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hready   (hready),
        .map_ok_i (map_ok),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .rd_en_o  (rd_en),
        .wr_en_o  (wr_en),
        .wr_addr_o(wr_addr)
    );

    // Register map decode: COUNT is read-only, everything else unmapped
    always_comb begin
        map_ok = 1'b0;
        case (a_off)
            TMR_CTRL, TMR_LOAD, TMR_STATUS: map_ok = 1'b1;
            TMR_COUNT:                      map_ok = ~hwrite;
`ifdef TIMER_PRESCALER_EN
            TMR_PRESC:                      map_ok = 1'b1;
`endif
            default:                        map_ok = 1'b0;
        endcase
    end

`ifdef TIMER_PRESCALER_EN
    logic [7:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic       presc_wr;

    assign presc_wr = wr_en & (w_off == TMR_PRESC);
    assign tick     = ctrl_q[CTRL_EN] & (pcnt_q == presc_q);

    // Prescale counter restarts on PRESC write, while disabled, and after each tick
    always_comb begin
        presc_d = presc_wr ? hwdata[7:0] : presc_q;
        if (presc_wr || !ctrl_q[CTRL_EN] || tick) begin
            pcnt_d = 8'd0;
        end else begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end

    // Prescaler state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= 8'd0;
            pcnt_q  <= 8'd0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    assign tick = ctrl_q[CTRL_EN];
`endif

    // Timer next state: tick first, bus write overrides it, expiry set overrides W1C
    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        expire    = 1'b0;
        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expire = 1'b1;
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = load_q;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end
        end
        if (wr_en) begin
            case (w_off)
                TMR_CTRL:   ctrl_d = hwdata[2:0];
                TMR_LOAD: begin
                    load_d  = hwdata;
                    count_d = hwdata;
                end
                TMR_STATUS: if (hwdata[0]) expired_d = 1'b0;
                default: ;
            endcase
        end
        if (expire) begin
            expired_d = 1'b1;
        end
    end

    // Read mux uses next-state values so a read right behind a write sees the new data
    always_comb begin
        rd_val = 32'd0;
        case (a_off)
            TMR_CTRL:   rd_val = {29'd0, ctrl_d};
            TMR_LOAD:   rd_val = load_d;
            TMR_COUNT:  rd_val = count_d;
            TMR_STATUS: rd_val = {31'd0, expired_d};
`ifdef TIMER_PRESCALER_EN
            TMR_PRESC:  rd_val = {24'd0, presc_d};
`endif
            default:    rd_val = 32'd0;
        endcase
        hrdata_d = rd_en ? rd_val : hrdata_q;
    end

    // Timer registers and read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= 3'd0;
            load_q    <= 32'd0;
            count_q   <= 32'd0;
            expired_q <= 1'b0;
            hrdata_q  <= 32'd0;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            hrdata_q  <= hrdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Self-checking bench for ahb_timer_slave: pipelined AHB driver fed from op tables, scoreboard of expected responses.
// Latency: n/a.
// Backpressure: driver holds the address phase while hreadyout is low.
module tb_ahb_timer_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        timer_irq;

    int n_checks = 0;
    int n_pass   = 0;
    int op_base  = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        err;
        logic        chk;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] rd;
        int          idx;
    } exp_t;

    vec_t ops[$];
    exp_t sb[$];

    always #5 clk = ~clk;
    assign hready = hreadyout;

    ahb_timer_slave #(.ADDR_W(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hprot    (hprot),
        .hwdata   (hwdata),
        .hready   (hready),
        .hrdata   (hrdata),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .timer_irq(timer_irq)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void add(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                input logic [31:0] wd, input logic er, input logic ck,
                                input logic [31:0] rd);
        vec_t v;
        v.addr = a; v.wr = w; v.size = sz; v.wdata = wd;
        v.err = er; v.chk = ck; v.rd = rd;
        ops.push_back(v);
    endfunction

    function automatic void w_op(input logic [31:0] a, input logic [31:0] d);
        add(a, 1'b1, 3'b010, d, 1'b0, 1'b0, 32'd0);
    endfunction

    function automatic void r_op(input logic [31:0] a, input logic [31:0] e);
        add(a, 1'b0, 3'b010, 32'd0, 1'b0, 1'b1, e);
    endfunction

    function automatic void e_op(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                 input logic [31:0] d);
        add(a, w, sz, d, 1'b1, 1'b0, 32'd0);
    endfunction

    // Pipelined master: address phase of op k overlaps data phase of op k-1
    task automatic run_ops();
        int   nxt = 0;
        int   guard = 0;
        int   waits = 0;
        int   idx_cur = 0;
        bit   prev_rdy = 1'b1;
        bit   addr_act = 1'b0;
        bit   dp_act = 1'b0;
        bit   wait_resp = 1'b0;
        vec_t cur;
        exp_t e;
        logic [31:0] code;
        while ((nxt < ops.size() || addr_act || dp_act) && guard < 1000) begin
            guard++;
            @(posedge clk); #1;
            if (prev_rdy) begin
                dp_act = addr_act;
                if (addr_act) begin
                    e.err = cur.err; e.chk = cur.chk; e.rd = cur.rd; e.idx = idx_cur;
                    sb.push_back(e);
                    hwdata = cur.wdata;
                end
                waits = 0;
                wait_resp = 1'b0;
                if (nxt < ops.size()) begin
                    cur = ops[nxt];
                    idx_cur = op_base + nxt;
                    nxt++;
                    addr_act = 1'b1;
                    hsel = 1'b1; haddr = cur.addr; htrans = 2'b10;
                    hwrite = cur.wr; hsize = cur.size;
                end else begin
                    addr_act = 1'b0;
                    hsel = 1'b0; haddr = 32'd0; htrans = 2'b00;
                    hwrite = 1'b0; hsize = 3'b010;
                end
            end
            @(negedge clk);
            prev_rdy = hreadyout;
            if (dp_act) begin
                if (!hreadyout) begin
                    waits++;
                    wait_resp = hresp;
                end else begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL scoreboard_underflow: got completion expected none");
                    end else begin
                        e = sb.pop_front();
                        code = {28'd0, hresp, wait_resp, waits == 1, waits > 1};
                        check($sformatf("op%0d_resp", e.idx), code, e.err ? 32'd14 : 32'd0);
                        if (e.chk) check($sformatf("op%0d_rdata", e.idx), hrdata, e.rd);
                    end
                    dp_act = 1'b0;
                end
            end
        end
        if (guard >= 1000) begin
            n_checks++;
            $display("FAIL run_ops_timeout: got %0d cycles expected under 1000", guard);
        end
        op_base += ops.size();
        ops.delete();
        sb.delete();
    endtask

    initial begin
        reset = 1'b1; hsel = 1'b0; haddr = 32'd0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b010; hprot = 4'b0011; hwdata = 32'd0;

        // Reset state
        @(negedge clk);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
        check("rst_hresp", {31'd0, hresp}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        r_op(32'h0, 32'd0); r_op(32'h4, 32'd0); r_op(32'h8, 32'd0); r_op(32'hC, 32'd0);
        run_ops();

        // One-shot countdown 5..0, EN clears, EXPIRED + irq
        w_op(32'h4, 32'd5);
        w_op(32'h0, 32'h5);
        r_op(32'h8, 32'd5); r_op(32'h8, 32'd4); r_op(32'h8, 32'd3); r_op(32'h8, 32'd2);
        r_op(32'h8, 32'd1); r_op(32'h8, 32'd0); r_op(32'h8, 32'd0);
        r_op(32'hC, 32'd1);
        r_op(32'h0, 32'h4);
        run_ops();
        check("irq_after_expiry", {31'd0, timer_irq}, 32'd1);
        w_op(32'hC, 32'd1);
        r_op(32'hC, 32'd0);
        run_ops();
        check("irq_after_clear", {31'd0, timer_irq}, 32'd0);

        // Auto-reload 2,1,0,2,...; W1C coinciding with expiry leaves EXPIRED set
        w_op(32'h4, 32'd2);
        w_op(32'h0, 32'h3);
        r_op(32'h8, 32'd2); r_op(32'h8, 32'd1); r_op(32'h8, 32'd0); r_op(32'h8, 32'd2);
        r_op(32'h8, 32'd1); r_op(32'h8, 32'd0); r_op(32'h8, 32'd2);
        r_op(32'hC, 32'd1);
        w_op(32'hC, 32'd1);
        r_op(32'hC, 32'd1);
        w_op(32'h0, 32'h0);
        w_op(32'hC, 32'd1);
        r_op(32'hC, 32'd0);
        run_ops();

        // Errors, including back-to-back ones; registers must stay CTRL=0 LOAD=2 COUNT=0
        e_op(32'h8, 1'b1, 3'b010, 32'h55);
        e_op(32'h0, 1'b0, 3'b000, 32'd0);
        e_op(32'h14, 1'b0, 3'b010, 32'd0);
        e_op(32'h2, 1'b0, 3'b010, 32'd0);
        e_op(32'h4, 1'b1, 3'b000, 32'h77);
        e_op(32'h1, 1'b1, 3'b010, 32'h7);
`ifndef TIMER_PRESCALER_EN
        e_op(32'h10, 1'b0, 3'b010, 32'd0);
`endif
        r_op(32'h3000_0004, 32'd2);
        r_op(32'h4, 32'd2);
        r_op(32'h8, 32'd0);
        r_op(32'h0, 32'd0);
        run_ops();

        // Back-to-back write then read
        w_op(32'h4, 32'hDEAD_BEEF);
        r_op(32'h4, 32'hDEAD_BEEF);
        r_op(32'h8, 32'hDEAD_BEEF);
        run_ops();

`ifdef TIMER_PRESCALER_EN
        w_op(32'h10, 32'd3);
        w_op(32'h4, 32'd2);
        w_op(32'h0, 32'h1);
        for (int i = 0; i < 4; i++) r_op(32'h8, 32'd2);
        for (int i = 0; i < 4; i++) r_op(32'h8, 32'd1);
        r_op(32'h8, 32'd0);
        r_op(32'h10, 32'd3);
        w_op(32'h0, 32'h0);
        run_ops();
`endif

        // Reset asserted during ERR1
        w_op(32'h4, 32'd1);
        w_op(32'h0, 32'h5);
        run_ops();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("irq_before_reset", {31'd0, timer_irq}, 32'd1);
        @(posedge clk); #1;
        hsel = 1'b1; haddr = 32'h14; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; haddr = 32'd0;
        @(negedge clk);
        check("err1_hreadyout", {31'd0, hreadyout}, 32'd0);
        check("err1_hresp", {31'd0, hresp}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst_hreadyout", {31'd0, hreadyout}, 32'd1);
        check("midrst_hresp", {31'd0, hresp}, 32'd0);
        check("midrst_hrdata", hrdata, 32'd0);
        check("midrst_irq", {31'd0, timer_irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        r_op(32'h0, 32'd0); r_op(32'h4, 32'd0); r_op(32'h8, 32'd0); r_op(32'hC, 32'd0);
        run_ops();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
